// File: rtl/lu_arbiter_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter: opcode
// encodings and the controller state encoding.
package lu_arbiter_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_GT   = 3'd6;
  localparam logic [2:0] OP_EQ   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } lu_state_e;

endpackage

// File: rtl/lu_core.sv
// Registered N-bit logic/compare unit; the result register loads when en_i is
// high and otherwise holds, so it doubles as the response data holder.
module lu_core
  import lu_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int OPW = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic [OPW-1:0] op_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [N-1:0]   y_o
);

  logic [N-1:0] y_d, y_q;

  // Any opcode outside the eight defined codes (including X bits) passes A.
  always_comb begin
    y_d = a_i;
    case (op_i)
      OPW'(OP_AND):  y_d = a_i & b_i;
      OPW'(OP_OR):   y_d = a_i | b_i;
      OPW'(OP_XOR):  y_d = a_i ^ b_i;
      OPW'(OP_NOR):  y_d = ~(a_i | b_i);
      OPW'(OP_NAND): y_d = ~(a_i & b_i);
      OPW'(OP_XNOR): y_d = ~(a_i ^ b_i);
      OPW'(OP_GT):   y_d = N'(a_i > b_i);
      OPW'(OP_EQ):   y_d = N'(a_i == b_i);
      default:       y_d = a_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_q <= '0;
    end else if (en_i) begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter between two requesters sharing one registered logic
// unit; IDLE grants and captures, EXEC computes, RESP holds until accepted.
module lu_arbiter
  import lu_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [N-1:0]   a0,
  input  logic [N-1:0]   b0,
  input  logic [OPW-1:0] op0,
  input  logic           req1,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   b1,
  input  logic [OPW-1:0] op1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           res_valid,
  output logic           res_id,
  output logic [N-1:0]   res_data,
  input  logic           res_ready,
  output logic           busy,
  output lu_state_e      dbg_state
);

  // Handshake: a request is accepted in the cycle gntX is high (operands are
  // captured on that edge); a result transfers on an edge with
  // res_valid && res_ready, and res_id/res_data are stable until then.

  lu_state_e      state_d, state_q;
  logic           last_d, last_q;   // requester served most recently
  logic [N-1:0]   a_d, a_q, b_d, b_q;
  logic [OPW-1:0] op_d, op_q;
  logic           id_d, id_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Grants are held off during reset so nothing is accepted and lost.
        if (!rst) begin
          if (req0 && (!req1 || last_q)) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
        end
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? a1 : a0;
          b_d     = gnt1 ? b1 : b0;
          op_d    = gnt1 ? op1 : op0;
          id_d    = gnt1;
          last_d  = gnt1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
    end
  end

  lu_core #(
    .N  (N),
    .OPW(OPW)
  ) u_core (
    .clk_i(clk),
    .rst_i(rst),
    .en_i (state_q == ST_EXEC),
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (res_data)
  );

  assign res_valid = (state_q == ST_RESP);
  assign res_id    = id_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lu_arbiter.sv
// Self-checking bench for lu_arbiter: directed scenarios plus randomized
// traffic, all scored against a transaction-level reference model.
module tb_lu_arbiter;
  import lu_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int OPW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [N-1:0]   a0, b0, a1, b1;
  logic [OPW-1:0] op0, op1;
  logic           gnt0, gnt1, res_valid, res_id, res_ready, busy;
  logic [N-1:0]   res_data;
  lu_state_e      dbg_state;

  lu_arbiter #(.N(N), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_ready(res_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [N:0] exp_q[$];   // {id, data} of accepted operations, oldest first
  bit m_idle = 1'b1;
  bit m_last = 1'b1;      // 1: requester 1 was served last
  int m_age  = 0;         // cycles since the grant of the in-flight operation

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_op(input logic [OPW-1:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return (a > b) ? N'(1) : N'(0);
      3'd7:    return (a == b) ? N'(1) : N'(0);
      default: return a;
    endcase
  endfunction

  // Called at the negedge: checks outputs against the protocol rules for the
  // current cycle, then advances the model across the coming edge.
  task automatic model_eval();
    bit e0, e1;
    logic [N:0] e;
    if (rst) begin
      check_eq("rst_gnt", {gnt1, gnt0}, 2'b00);
      m_idle = 1'b1;
      m_last = 1'b1;
      exp_q.delete();
      return;
    end
    if (m_idle) begin
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_valid", res_valid, 1'b0);
      e0 = req0 && (!req1 || m_last);
      e1 = req1 && !e0;
      check_eq("arb_gnt", {gnt1, gnt0}, {e1, e0});
      if (e0 || e1) begin
        exp_q.push_back(e1 ? {1'b1, ref_op(op1, a1, b1)} : {1'b0, ref_op(op0, a0, b0)});
        m_last = e1;
        m_idle = 1'b0;
        m_age  = 0;
      end
    end else begin
      m_age++;
      check_eq("busy_gnt", {gnt1, gnt0}, 2'b00);
      check_eq("busy_hi", busy, 1'b1);
      if (m_age == 1) begin
        check_eq("exec_valid", res_valid, 1'b0);
      end else begin
        check_eq("resp_valid", res_valid, 1'b1);
        if (exp_q.size() == 0) begin
          check_eq("resp_queue", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q[0];
          check_eq("resp_result", {res_id, res_data}, e);
          if (res_ready) begin
            void'(exp_q.pop_front());
            m_idle = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req0 = 1'b0;
    req1 = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    res_ready = 1'b1;
    sample();
    advance();
    sample();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", res_valid, 1'b0);
    check_eq("rst_id", res_id, 1'b0);
    check_eq("rst_data", res_data, '0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    advance();
    rst = 1'b0;
  endtask

  // One isolated operation: grant expected in the first cycle, result two
  // cycles after the grant edge.
  task automatic run_op(input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [OPW-1:0] op, input logic [N-1:0] exp, input string tag);
    bit granted;
    int k;
    res_ready = 1'b1;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    granted = 1'b0;
    k = 0;
    while (!granted && k < 8) begin
      sample();
      granted = id ? gnt1 : gnt0;
      advance();
      k++;
    end
    check_eq({tag, "_gnt_cycle"}, 32'(k), 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    sample();
    check_eq({tag, "_c1_valid"}, res_valid, 1'b0);
    advance();
    sample();
    check_eq({tag, "_c2_valid"}, res_valid, 1'b1);
    check_eq({tag, "_data"}, res_data, exp);
    check_eq({tag, "_id"}, res_id, id);
    advance();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gq[$];
    logic [N:0] rq[$];
    bit p0, p1;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    do_reset();

    // Single AND from requester 0.
    run_op(1'b0, 4'hC, 4'hA, 3'd0, 4'h8, "and0");

    // Both held: grants alternate starting from requester 0.
    do_reset();
    req0 = 1'b1; a0 = 4'hC; b0 = 4'hA; op0 = 3'd2;
    req1 = 1'b1; a1 = 4'h5; b1 = 4'h5; op1 = 3'd7;
    res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sample();
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
      if (res_valid && res_ready) rq.push_back({res_id, res_data});
      advance();
    end
    check_eq("rr_count", 32'(gq.size()), 32'd3);
    check_eq("rr_results", 32'(rq.size()), 32'd3);
    if (gq.size() >= 3) begin
      check_eq("rr_g0", 32'(gq[0]), 32'd0);
      check_eq("rr_g1", 32'(gq[1]), 32'd1);
      check_eq("rr_g2", 32'(gq[2]), 32'd0);
    end
    if (rq.size() >= 2) begin
      check_eq("rr_r0", rq[0], {1'b0, 4'h6});
      check_eq("rr_r1", rq[1], {1'b1, 4'h1});
    end
    idle_cycles(4);

    // Back-pressure in RESP for five cycles.
    req0 = 1'b1; a0 = 4'h3; b0 = 4'h5; op0 = 3'd1; res_ready = 1'b0;
    sample();
    check_eq("bp_gnt", gnt0, 1'b1);
    advance();
    req0 = 1'b0;
    sample();
    advance();
    req0 = 1'b1; req1 = 1'b1; a1 = 4'h9; b1 = 4'h1; op1 = 3'd4;
    for (int i = 0; i < 5; i++) begin
      sample();
      check_eq("bp_valid", res_valid, 1'b1);
      check_eq("bp_data", res_data, 4'h7);
      check_eq("bp_gnt_low", {gnt1, gnt0}, 2'b00);
      check_eq("bp_busy", busy, 1'b1);
      advance();
    end
    res_ready = 1'b1;
    sample();
    advance();
    sample();
    check_eq("bp_idle_busy", busy, 1'b0);
    check_eq("bp_idle_gnt1", gnt1, 1'b1);
    advance();
    idle_cycles(4);

    // Compare and NOR corner cases.
    run_op(1'b0, 4'h3, 4'h9, 3'd6, 4'h0, "gt_lo");
    run_op(1'b0, 4'h9, 4'h3, 3'd6, 4'h1, "gt_hi");
    run_op(1'b1, 4'h0, 4'h0, 3'd3, 4'hF, "nor0");

    // Reset during EXEC abandons the operation.
    req0 = 1'b1; a0 = 4'hF; b0 = 4'h3; op0 = 3'd0; res_ready = 1'b1;
    sample();
    check_eq("mid_gnt0", gnt0, 1'b1);
    advance();
    req0 = 1'b0;
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    req1 = 1'b1; a1 = 4'h6; b1 = 4'h3; op1 = 3'd1;
    sample();
    check_eq("mid_busy", busy, 1'b0);
    check_eq("mid_valid", res_valid, 1'b0);
    check_eq("mid_gnt1", gnt1, 1'b1);
    advance();
    req1 = 1'b0;
    sample();
    advance();
    sample();
    check_eq("mid_res", {res_id, res_data}, {1'b1, 4'h7});
    advance();
    idle_cycles(3);

    // Randomized traffic; requests held until granted.
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1;
        a0 = N'($urandom_range(0, 15)); b0 = N'($urandom_range(0, 15));
        op0 = OPW'($urandom_range(0, 7));
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1;
        a1 = N'($urandom_range(0, 15)); b1 = N'($urandom_range(0, 15));
        op1 = OPW'($urandom_range(0, 7));
      end
      req0 = p0;
      req1 = p1;
      res_ready = ($urandom_range(0, 3) != 0);
      sample();
      if (gnt0) p0 = 1'b0;
      if (gnt1) p1 = 1'b0;
      advance();
    end
    rst = 1'b0;
    idle_cycles(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lu_arbiter.md
LU_ARBITER -- requirements
Module: lu_arbiter

Interface
REQ-001 Parameter N, default 4, operand/result width in bits.
REQ-002 Parameter OPW, default 3, opcode width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  requester 0 has an operation pending; held until gnt0.
REQ-006 a0, b0  input  N each  requester 0 operands.
REQ-007 op0  input  OPW  requester 0 opcode.
REQ-008 req1, a1, b1, op1  input  1/N/N/OPW  requester 1, same meaning as requester 0.
REQ-009 gnt0, gnt1  output  1 each  request accepted this cycle; operands captured at this clock edge.
REQ-010 res_valid  output  1  result available.
REQ-011 res_id  output  1  requester that owns the result.
REQ-012 res_data  output  N  operation result.
REQ-013 res_ready  input  1  consumer accepts result when high with res_valid.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Opcodes SHALL be: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 (A>B unsigned ? 1 : 0), 7 (A==B ? 1 : 0); compare results zero-extended to N.
REQ-016 FSM SHALL have states IDLE, EXEC and RESP.
REQ-017 IDLE: with any req high, the FSM SHALL assert exactly one gnt combinationally, capture that requester's a, b, op and id, and move to EXEC; with no req, it stays in IDLE.
REQ-018 Arbitration SHALL be round-robin: with both req high, grant the requester not served last; with one req high, grant it regardless of pointer.
REQ-019 The last-served pointer SHALL update only on a grant.
REQ-020 EXEC SHALL last exactly one cycle, registering the result, then go to RESP.
REQ-021 RESP: res_valid SHALL be high and res_id/res_data stable until res_valid&&res_ready; on that edge the FSM SHALL return to IDLE.
REQ-022 Latency SHALL be 2 cycles from the grant edge to res_valid high; back-to-back issue minimum period is 3 cycles at res_ready=1.
REQ-023 gnt0/gnt1 SHALL never be high outside IDLE and never both high.
REQ-024 Requests arriving in EXEC/RESP SHALL be ignored until IDLE; no request is dropped while req is held.
REQ-025 Undefined/unknown opcode bits SHALL yield res_data = A.

Reset
REQ-026 On rst high at a clock edge: state IDLE, pointer favouring requester 0, res_valid 0, res_id 0, res_data 0, busy 0, gnt0/gnt1 0.
REQ-027 Reset mid-operation SHALL abandon the in-flight operation with no result issued.

Structure
REQ-028 Opcode encodings (8 constants) and FSM state encoding SHALL live in a shared ALU package.
REQ-029 One sub-module, lu_core, SHALL implement REQ-015 as a registered N-bit operation unit used in EXEC.
REQ-030 Arbiter, FSM and result holding register SHALL reside in lu_arbiter.

Verification
REQ-031 Reset then req0=1, a0=4'hC, b0=4'hA, op0=0 -> gnt0 in cycle 0, res_valid in cycle 2, res_data=4'h8, res_id=0.
REQ-032 req0 and req1 both held, ops 2 (C^A) and 7 (5==5) -> grants alternate 0,1,0; results 4'h6 id0, 4'h1 id1.
REQ-033 res_ready=0 for 5 cycles in RESP -> res_valid and res_data stable; gnt low; busy high; IDLE one cycle after res_ready=1.
REQ-034 op=6, A=4'h3, B=4'h9 -> 4'h0; A=4'h9, B=4'h3 -> 4'h1; op=3, A=B=0 -> 4'hF.
REQ-035 rst asserted during EXEC -> next cycle busy=0, res_valid=0; a subsequent req1 alone is granted immediately.
